// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - mode encodings and default widths for adc_decimator
package adc_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RATIO_W = 16;
  localparam int DEF_SHIFT_W = 4;

  typedef enum logic [1:0] {
    MODE_SAMPLE  = 2'b00,
    MODE_AVERAGE = 2'b01,
    MODE_PEAK    = 2'b10,
    MODE_TEST    = 2'b11
  } mode_e;

endpackage

// File: rtl/adc_decim_acc.sv
// rtl/adc_decim_acc.sv - per-sample sum/min/max/last combine with frame state
module adc_decim_acc
  import adc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_DATA_W + (1 << DEF_SHIFT_W) - 1
) (
  input  logic              adc_dco,
  input  logic              adc_rst_n,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic              i_first,
  input  logic [DATA_W-1:0] i_sample,
  output logic [ACC_W-1:0]  o_sum,
  output logic [DATA_W-1:0] o_min,
  output logic [DATA_W-1:0] o_max,
  output logic [DATA_W-1:0] o_last
);

  logic [ACC_W-1:0]  r_sum;
  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;

  // Outputs already include the current sample; the first sample of a frame seeds.
  always_comb begin
    o_last = i_sample;
    if (i_first) begin
      o_sum = ACC_W'(i_sample);
      o_min = i_sample;
      o_max = i_sample;
    end else begin
      o_sum = r_sum + ACC_W'(i_sample);
      o_min = (i_sample < r_min) ? i_sample : r_min;
      o_max = (i_sample > r_max) ? i_sample : r_max;
    end
  end

  always_ff @(posedge adc_dco or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_sum <= '0;
      r_min <= '0;
      r_max <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
      r_min <= '0;
      r_max <= '0;
    end else if (i_accept) begin
      r_sum <= o_sum;
      r_min <= o_min;
      r_max <= o_max;
    end
  end

endmodule

// File: rtl/adc_decimator.sv
// rtl/adc_decimator.sv - frame counter, config latch and output register for ADC decimation
module adc_decimator
  import adc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RATIO_W = DEF_RATIO_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic               adc_dco,
  input  logic               adc_rst_n,
  input  logic [DATA_W-1:0]  adc_in,
  input  logic               adc_in_valid,
  input  logic               enable,
  input  logic               restart,
  input  logic [1:0]         mode,
  input  logic [RATIO_W-1:0] decimation,
  input  logic [SHIFT_W-1:0] avg_log2,
  output logic [DATA_W-1:0]  out_data,
  output logic [DATA_W-1:0]  out_max,
  output logic               out_valid
);

  localparam int ACC_W = DATA_W + (1 << SHIFT_W) - 1;
  localparam int CNT_W = RATIO_W + 1;

  logic [CNT_W-1:0]   r_cnt;
  mode_e              r_mode;
  logic [RATIO_W-1:0] r_dec;
  logic [SHIFT_W-1:0] r_log2;
  logic [DATA_W-1:0]  r_pat;
  logic [DATA_W-1:0]  r_data;
  logic [DATA_W-1:0]  r_max;
  logic               r_valid;

  logic               w_accept;
  logic               w_first;
  logic               w_end;
  mode_e              w_mode;
  logic [RATIO_W-1:0] w_dec;
  logic [SHIFT_W-1:0] w_log2;
  logic [CNT_W-1:0]   w_last_idx;
  logic [ACC_W-1:0]   w_sum;
  logic [DATA_W-1:0]  w_avg;
  logic [DATA_W-1:0]  w_min;
  logic [DATA_W-1:0]  w_max;
  logic [DATA_W-1:0]  w_last;

  assign w_accept = adc_in_valid & enable & ~restart;
  assign w_first  = (r_cnt == '0);

  // On the first sample of a frame the live config applies, so a 1-sample frame sees it too.
  assign w_mode = w_first ? mode_e'(mode) : r_mode;
  assign w_dec  = w_first ? decimation : r_dec;
  assign w_log2 = w_first ? avg_log2 : r_log2;

  assign w_last_idx = (w_mode == MODE_AVERAGE) ? ((CNT_W'(1) << w_log2) - CNT_W'(1))
                                               : {1'b0, w_dec};
  assign w_end = w_accept & (r_cnt == w_last_idx);
  assign w_avg = DATA_W'(w_sum >> w_log2);

  adc_decim_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .adc_dco   (adc_dco),
    .adc_rst_n (adc_rst_n),
    .i_clear   (restart),
    .i_accept  (w_accept),
    .i_first   (w_first),
    .i_sample  (adc_in),
    .o_sum     (w_sum),
    .o_min     (w_min),
    .o_max     (w_max),
    .o_last    (w_last)
  );

  always_ff @(posedge adc_dco or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_cnt  <= '0;
      r_mode <= MODE_SAMPLE;
      r_dec  <= '0;
      r_log2 <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_end ? '0 : r_cnt + CNT_W'(1);
      if (w_first) begin
        r_mode <= mode_e'(mode);
        r_dec  <= decimation;
        r_log2 <= avg_log2;
      end
    end
  end

  always_ff @(posedge adc_dco or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_max   <= '0;
      r_pat   <= '0;
    end else begin
      r_valid <= w_end;
      if (w_end) begin
        r_max <= '0;
        case (w_mode)
          MODE_SAMPLE:  r_data <= w_last;
          MODE_AVERAGE: r_data <= w_avg;
          MODE_PEAK: begin
            r_data <= w_min;
            r_max  <= w_max;
          end
          default: begin
            r_data <= r_pat;
            r_pat  <= r_pat + DATA_W'(1);
          end
        endcase
      end
    end
  end

  assign out_data  = r_data;
  assign out_max   = r_max;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_adc_decimator.sv
// tb/tb_adc_decimator.sv - randomized self-checking bench for adc_decimator
module tb_adc_decimator;
  import adc_pkg::*;

  localparam int DATA_W  = 8;
  localparam int RATIO_W = 16;
  localparam int SHIFT_W = 4;

  logic               adc_dco = 1'b0;
  logic               adc_rst_n = 1'b0;
  logic [DATA_W-1:0]  adc_in = '0;
  logic               adc_in_valid = 1'b0;
  logic               enable = 1'b1;
  logic               restart = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic [RATIO_W-1:0] decimation = '0;
  logic [SHIFT_W-1:0] avg_log2 = '0;
  logic [DATA_W-1:0]  out_data;
  logic [DATA_W-1:0]  out_max;
  logic               out_valid;

  int checks = 0;
  int failures = 0;

  int q[$];
  int m_mode = 0, m_dec = 0, m_log2 = 0, m_pat = 0;
  int e_data = 0, e_max = 0, e_valid = 0;
  int n_strobe;

  adc_decimator #(
    .DATA_W  (DATA_W),
    .RATIO_W (RATIO_W),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .adc_dco      (adc_dco),
    .adc_rst_n    (adc_rst_n),
    .adc_in       (adc_in),
    .adc_in_valid (adc_in_valid),
    .enable       (enable),
    .restart      (restart),
    .mode         (mode),
    .decimation   (decimation),
    .avg_log2     (avg_log2),
    .out_data     (out_data),
    .out_max      (out_max),
    .out_valid    (out_valid)
  );

  always #5 adc_dco = ~adc_dco;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_dec = 0; m_log2 = 0; m_pat = 0;
    e_data = 0; e_max = 0; e_valid = 0;
  endtask

  // Frame model: collect accepted samples, reduce the whole frame once it reaches N.
  task automatic model_step(input bit v, input int d, input bit e, input bit r);
    int n, s, lo, hi;
    e_valid = 0;
    if (r) begin
      q.delete();
    end else if (v && e) begin
      if (q.size() == 0) begin
        m_mode = int'(mode); m_dec = int'(decimation); m_log2 = int'(avg_log2);
      end
      q.push_back(d);
      n = (m_mode == 1) ? (1 << m_log2) : m_dec + 1;
      if (q.size() == n) begin
        e_valid = 1;
        e_max = 0;
        case (m_mode)
          0: e_data = q[q.size()-1];
          1: begin
            s = 0;
            foreach (q[i]) s += q[i];
            e_data = (s >> m_log2) % 256;
          end
          2: begin
            lo = 255; hi = 0;
            foreach (q[i]) begin
              if (q[i] < lo) lo = q[i];
              if (q[i] > hi) hi = q[i];
            end
            e_data = lo; e_max = hi;
          end
          default: begin
            e_data = m_pat;
            m_pat = (m_pat + 1) % 256;
          end
        endcase
        q.delete();
      end
    end
  endtask

  task automatic cycle(input bit v, input int d, input bit e, input bit r);
    adc_in_valid = v;
    adc_in = DATA_W'(d);
    enable = e;
    restart = r;
    @(posedge adc_dco);
    model_step(v, d, e, r);
    #1;
    check("valid", {31'b0, out_valid}, e_valid);
    check("data", {24'b0, out_data}, e_data);
    check("max", {24'b0, out_max}, e_max);
    if (out_valid) n_strobe++;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge adc_dco);
    #1;
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_data", {24'b0, out_data}, 0);
    check("rst_max", {24'b0, out_max}, 0);
    adc_rst_n = 1'b1;

    mode = 2'b00; decimation = 3; n_strobe = 0;
    for (int i = 0; i < 12; i++) cycle(1, i, 1, 0);
    check("sample_strobes", n_strobe, 3);

    mode = 2'b01; avg_log2 = 2;
    cycle(1, 10, 1, 0); cycle(1, 20, 1, 0); cycle(1, 30, 1, 0); cycle(1, 41, 1, 0);
    check("avg_25", {24'b0, out_data}, 25);
    avg_log2 = 0;
    for (int i = 0; i < 4; i++) cycle(1, 255, 1, 0);
    check("avg_255", {24'b0, out_data}, 255);

    mode = 2'b10; decimation = 4;
    cycle(1, 9, 1, 0); cycle(1, 3, 1, 0); cycle(1, 200, 1, 0); cycle(1, 7, 1, 0); cycle(1, 50, 1, 0);
    check("peak_min", {24'b0, out_data}, 3);
    check("peak_max", {24'b0, out_max}, 200);

    mode = 2'b11; decimation = 0; n_strobe = 0;
    for (int i = 0; i < 260; i++) cycle(1, $urandom_range(0, 255), 1, 0);
    check("test_strobes", n_strobe, 260);
    check("test_wrap", {24'b0, out_data}, 3);

    mode = 2'b00; decimation = 3; n_strobe = 0;
    cycle(1, 1, 1, 0); cycle(1, 2, 1, 0); cycle(1, 3, 1, 0); cycle(1, 4, 1, 1);
    cycle(0, 0, 1, 0);
    check("restart_nostrobe", n_strobe, 0);
    cycle(1, 5, 1, 0); cycle(1, 6, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 99, 0, 0);
    cycle(1, 7, 1, 0); cycle(1, 8, 1, 0);
    check("enable_gap_data", {24'b0, out_data}, 8);
    cycle(1, 9, 1, 0); cycle(1, 10, 1, 0);

    @(posedge adc_dco);
    #3 adc_rst_n = 1'b0;
    #1;
    model_reset();
    check("async_valid", {31'b0, out_valid}, 0);
    check("async_data", {24'b0, out_data}, 0);
    check("async_max", {24'b0, out_max}, 0);
    adc_in_valid = 1'b0;
    @(posedge adc_dco);
    #1 adc_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1, 20 + i, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        mode = 2'($urandom_range(0, 3));
        decimation = RATIO_W'($urandom_range(0, 4));
        avg_log2 = SHIFT_W'($urandom_range(0, 3));
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 255),
            $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_decimator.md
ADC_DECIMATOR -- requirements
Module: adc_decimator

Interface
REQ-001 Parameter DATA_W, default 8: ADC sample width in bits.
REQ-002 Parameter RATIO_W, default 16: width of the decimation ratio input.
REQ-003 Parameter SHIFT_W, default 4: width of the averaging log2-window input.
REQ-004 Port adc_dco  in  1: sole clock; all logic rising-edge.
REQ-005 Port adc_rst_n  in  1: reset; one clock, reset asynchronous and active-low.
REQ-006 Port adc_in  in  DATA_W: unsigned ADC sample.
REQ-007 Port adc_in_valid  in  1: adc_in holds a new sample this cycle.
REQ-008 Port enable  in  1: sample acceptance gate.
REQ-009 Port restart  in  1: synchronous frame abort.
REQ-010 Port mode  in  2: 00 SAMPLE, 01 AVERAGE, 10 PEAK, 11 TEST.
REQ-011 Port decimation  in  RATIO_W: frame length N = decimation+1 (SAMPLE, PEAK, TEST).
REQ-012 Port avg_log2  in  SHIFT_W: AVERAGE frame length N = 2^avg_log2.
REQ-013 Port out_data  out  DATA_W: frame result (PEAK: minimum).
REQ-014 Port out_max  out  DATA_W: PEAK maximum; 0 in other modes.
REQ-015 Port out_valid  out  1: one-cycle strobe per completed frame.

Function
REQ-016 Sample accepted iff adc_in_valid & enable & !restart.
REQ-017 Sample counter cnt (RATIO_W+1 bits) increments per accepted sample; frame ends on accepting sample with cnt == N-1, cnt then returns to 0.
REQ-018 mode, decimation, avg_log2 latched on first accepted sample of a frame (cnt == 0); mid-frame changes take effect next frame.
REQ-019 out_valid asserted exactly the cycle after the frame-ending sample; out_data/out_max updated same edge and held until next frame end.
REQ-020 SAMPLE: out_data = last sample of frame.
REQ-021 AVERAGE: accumulator width DATA_W+2^SHIFT_W-1 bits, never overflows; out_data = sum >> avg_log2 (truncating).
REQ-022 PEAK: running min/max seeded by first sample of frame; out_data = min, out_max = max.
REQ-023 TEST: adc_in ignored; out_data = internal pattern counter, counter incremented after each TEST frame, wraps 2^DATA_W-1 -> 0.
REQ-024 decimation = 0 (or avg_log2 = 0): every accepted sample completes a frame; out_valid may stay high on consecutive cycles.
REQ-025 enable low: cnt, accumulator, min/max hold; frame resumes when enable returns.
REQ-026 restart: cnt and accumulators cleared next edge, no out_valid for the aborted frame; restart coincident with frame-ending sample suppresses that output; outputs and pattern counter unaffected.

Reset
REQ-027 On adc_rst_n low: out_data = 0, out_max = 0, out_valid = 0, cnt = 0, accumulator = 0, pattern counter = 0, latched mode = SAMPLE.
REQ-028 Reset asserted mid-frame discards the partial frame; first frame after release starts at cnt = 0.

Structure
REQ-029 Package adc_pkg holds mode encodings (MODE_SAMPLE/AVERAGE/PEAK/TEST) and default DATA_W/RATIO_W/SHIFT_W constants.
REQ-030 Per-sample combine logic (sum, min, max, last) in one sub-module adc_decim_acc; frame counter, config latch and output register in adc_decimator.

Verification
REQ-031 SAMPLE, decimation=3, adc_in 0..11 continuous valid -> out_valid 3 times, out_data 3, 7, 11, each one cycle after input 3/7/11.
REQ-032 AVERAGE, avg_log2=2, inputs 10,20,30,41 -> out_data 25 (101>>2), one strobe; avg_log2=0, DATA_W=8, inputs 255 x4 -> out_data 255 each cycle.
REQ-033 PEAK, decimation=4, inputs 9,3,200,7,50 -> out_data 3, out_max 200.
REQ-034 TEST, decimation=0, 260 valid cycles -> out_data 0..255,0..3 with out_valid every cycle after the first.
REQ-035 SAMPLE decimation=3: restart on 4th sample -> no strobe; enable low 5 cycles mid-frame -> strobe delayed exactly 5 cycles; adc_rst_n low mid-frame -> all outputs 0 asynchronously.
